// File: rtl/aes_decryption_block.sv
// Iterative AES inverse cipher: one S-box column per cycle, round keys fetched by index.
// Optional macro AES_DEC_AES256_EN adds keyLen to select 14 rounds (AES-256) per run.
module aes_decryption_block #(
    parameter logic [3:0] LAST_ROUND = 4'ha
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
`ifdef AES_DEC_AES256_EN
    input  logic         keyLen,
`endif
    output logic [3:0]   round,
    input  logic [127:0] roundKey,
    output logic [31:0]  beforeSub,
    input  logic [31:0]  afterSub,
    input  logic [127:0] block,
    output logic [127:0] newBlock,
    output logic         ready
);

    // Handshake: a run starts when next=1 is sampled while ready=1 (IDLE); next is
    // ignored otherwise. ready drops on that edge and returns with newBlock valid.
    typedef enum logic [1:0] {S_IDLE, S_INIT, S_SBOX, S_MAIN} state_t;

    state_t       state, state_nxt;
    logic [127:0] st_q, st_nxt;
    logic [3:0]   round_q, round_nxt;
    logic [1:0]   ctr_q, ctr_nxt;
    logic         ready_q, ready_nxt;
    logic [3:0]   nr_sel;

`ifdef AES_DEC_AES256_EN
    assign nr_sel = keyLen ? 4'd14 : LAST_ROUND;
`else
    assign nr_sel = LAST_ROUND;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = w[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
    endfunction

    // Row r of output column c comes from input column (c - r) mod 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-32*c-8*r -: 8] = s[127-32*((c-r+4)%4)-8*r -: 8];
            end
        end
        return o;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            st_q    <= '0;
            round_q <= '0;
            ctr_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            st_q    <= st_nxt;
            round_q <= round_nxt;
            ctr_q   <= ctr_nxt;
            ready_q <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        st_nxt    = st_q;
        round_nxt = round_q;
        ctr_nxt   = ctr_q;
        ready_nxt = ready_q;
        beforeSub = '0;
        case (state)
            S_IDLE: begin
                if (next) begin
                    round_nxt = nr_sel;
                    ready_nxt = 1'b0;
                    state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                st_nxt    = inv_shift_rows(block ^ roundKey);
                round_nxt = round_q - 4'd1;
                ctr_nxt   = 2'd0;
                state_nxt = S_SBOX;
            end
            S_SBOX: begin
                case (ctr_q)
                    2'd0: begin beforeSub = st_q[127:96]; st_nxt[127:96] = afterSub; end
                    2'd1: begin beforeSub = st_q[95:64];  st_nxt[95:64]  = afterSub; end
                    2'd2: begin beforeSub = st_q[63:32];  st_nxt[63:32]  = afterSub; end
                    default: begin beforeSub = st_q[31:0]; st_nxt[31:0] = afterSub; end
                endcase
                ctr_nxt = ctr_q + 2'd1;
                if (ctr_q == 2'd3) state_nxt = S_MAIN;
            end
            S_MAIN: begin
                if (round_q != 4'd0) begin
                    st_nxt    = inv_shift_rows(inv_mix_columns(st_q ^ roundKey));
                    round_nxt = round_q - 4'd1;
                    ctr_nxt   = 2'd0;
                    state_nxt = S_SBOX;
                end else begin
                    // Final AddRoundKey with key 0; round stays 0 while idle.
                    st_nxt    = st_q ^ roundKey;
                    ready_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign round    = round_q;
    assign newBlock = st_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_aes_decryption_block.sv
// Bench for aes_decryption_block: key-schedule ROM and inverse S-box models, FIPS-197
// vectors, round/beforeSub sequencing, next chatter, mid-run reset and random round trips.
module tb_aes_decryption_block;

    logic         clk;
    logic         reset;
    logic         next;
    logic         keyLen;
    logic [3:0]   round;
    logic [127:0] roundKey;
    logic [31:0]  beforeSub;
    logic [31:0]  afterSub;
    logic [127:0] block;
    logic [127:0] newBlock;
    logic         ready;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox     [0:255];
    logic [7:0]   inv_sbox [0:255];
    logic [127:0] rk       [0:15];

    logic [127:0] exp_q [$];
    logic [3:0]   seen_round [$];
    logic [31:0]  seen_bs [$];

    localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;

    aes_decryption_block dut (
        .clk       (clk),
        .reset     (reset),
        .next      (next),
`ifdef AES_DEC_AES256_EN
        .keyLen    (keyLen),
`endif
        .round     (round),
        .roundKey  (roundKey),
        .beforeSub (beforeSub),
        .afterSub  (afterSub),
        .block     (block),
        .newBlock  (newBlock),
        .ready     (ready)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- environment models ----------------
    assign roundKey = rk[round];
    assign afterSub = {inv_sbox[beforeSub[31:24]], inv_sbox[beforeSub[23:16]],
                       inv_sbox[beforeSub[15:8]],  inv_sbox[beforeSub[7:0]]};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv, s, xb, yb;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                yb = y[7:0];
                if (x != 0 && gmul(xb, yb) == 8'h01) inv = yb;
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]     = s;
            inv_sbox[s] = xb;
        end
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // FIPS-197 key expansion; nk=4 uses the upper 128 key bits.
    function automatic void set_key(input logic [255:0] key, input int nk);
        logic [31:0] w [0:63];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nr;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = 128'h0;
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Forward cipher on a byte array s[4*col+row], using the current key ROM.
    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] k, o;
        k = rk[0];
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                if (rd != nr) begin
                    s[4*c+0] = gmul(t[4*c],8'h02) ^ gmul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h02) ^ gmul(t[4*c+2],8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h02) ^ gmul(t[4*c+3],8'h03);
                    s[4*c+3] = gmul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            k = rk[rd];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge where ready is seen high.
    // mode 0: one-cycle pulse, 1: next held high, 2: random next/keyLen chatter.
    task automatic do_run(input logic [127:0] blk, input logic kl, input int mode,
                          output int lat, output logic rdy_low, output logic [127:0] res);
        block  = blk;
        next   = 1'b1;
        keyLen = kl;
        @(negedge clk);
        rdy_low = ~ready;
        seen_round.delete();
        seen_bs.delete();
        seen_round.push_back(round);
        seen_bs.push_back(beforeSub);
        lat = 0;
        if (mode == 0) next = 1'b0;
        while (ready !== 1'b1 && lat < 200) begin
            if (mode == 2) begin
                next   = 1'($urandom_range(0, 1));
                keyLen = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
            seen_round.push_back(round);
            seen_bs.push_back(beforeSub);
        end
        next = 1'b0;
        res  = newBlock;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        total++; if (newBlock !== 128'h0) begin bad++; $display("FAIL reset_newblock: got %h want 0", newBlock); end
        total++; if (round !== 4'h0) begin bad++; $display("FAIL reset_round: got %0d want 0", round); end
        total++; if (beforeSub !== 32'h0) begin bad++; $display("FAIL reset_beforesub: got %h want 0", beforeSub); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips128(input int mode, input string tag);
        int lat; logic rl; logic [127:0] res, exp;
        set_key({KEY128, 128'h0}, 4);
        exp_q.push_back(PT);
        do_run(CT128, 1'b0, mode, lat, rl, res);
        exp = exp_q.pop_front();
        total++; if (rl !== 1'b1) begin bad++; $display("FAIL %s_ready_low: ready not low after start", tag); end
        total++; if (lat != 51) begin bad++; $display("FAIL %s_latency: got %0d want 51", tag, lat); end
        total++; if (res !== exp) begin bad++; $display("FAIL %s_result: got %h want %h", tag, res, exp); end
    endtask

    task automatic test_sequence(input logic [127:0] blk, input logic kl, input int nr);
        int lat; logic rl; logic [127:0] res;
        logic [3:0] exp_round_q [$];
        logic       exp_sbox_q  [$];
        int nz;
        exp_round_q.push_back(4'(nr));
        exp_sbox_q.push_back(1'b0);
        for (int r = nr - 1; r >= 0; r--) begin
            for (int k = 0; k < 5; k++) begin
                exp_round_q.push_back(4'(r));
                exp_sbox_q.push_back(k < 4);
            end
        end
        exp_round_q.push_back(4'h0);
        exp_sbox_q.push_back(1'b0);
        do_run(blk, kl, 0, lat, rl, res);
        total++;
        if (seen_round.size() != exp_round_q.size()) begin
            bad++; $display("FAIL seq_length: got %0d want %0d", seen_round.size(), exp_round_q.size());
        end else begin
            nz = 0;
            for (int i = 0; i < exp_round_q.size(); i++) begin
                total++;
                if (seen_round[i] !== exp_round_q[i]) begin
                    bad++; $display("FAIL seq_round[%0d]: got %0d want %0d", i, seen_round[i], exp_round_q[i]);
                end
                if (exp_sbox_q[i]) begin
                    if (seen_bs[i] != 32'h0) nz++;
                end else begin
                    total++;
                    if (seen_bs[i] !== 32'h0) begin
                        bad++; $display("FAIL seq_beforesub_idle[%0d]: got %h want 0", i, seen_bs[i]);
                    end
                end
            end
            total++;
            if (nz != 4*nr) begin bad++; $display("FAIL seq_sbox_cycles: got %0d want %0d", nz, 4*nr); end
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic rl; logic [127:0] res, exp, pt2;
        set_key({KEY128, 128'h0}, 4);
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back(PT);
        exp_q.push_back(pt2);
        do_run(CT128, 1'b0, 0, lat, rl, res);
        exp = exp_q.pop_front();
        total++; if (res !== exp) begin bad++; $display("FAIL b2b_first: got %h want %h", res, exp); end
        do_run(encrypt(pt2, 10), 1'b0, 0, lat, rl, res);
        exp = exp_q.pop_front();
        total++; if (lat != 51) begin bad++; $display("FAIL b2b_latency: got %0d want 51", lat); end
        total++; if (res !== exp) begin bad++; $display("FAIL b2b_second: got %h want %h", res, exp); end
    endtask

    task automatic test_reset_midrun();
        set_key({KEY128, 128'h0}, 4);
        block = CT128;
        next  = 1'b1;
        @(negedge clk);
        next  = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL midreset_ready: got %b want 1", ready); end
        total++; if (newBlock !== 128'h0) begin bad++; $display("FAIL midreset_newblock: got %h want 0", newBlock); end
        total++; if (round !== 4'h0) begin bad++; $display("FAIL midreset_round: got %0d want 0", round); end
        test_fips128(0, "after_reset");
    endtask

    task automatic test_round_trip(input int n, input int nk);
        int lat; logic rl; logic [127:0] res, exp, pt, ct;
        logic [255:0] key;
        for (int i = 0; i < n; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            set_key(key, nk);
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = encrypt(pt, nk + 6);
            exp_q.push_back(pt);
            do_run(ct, nk == 8, 0, lat, rl, res);
            exp = exp_q.pop_front();
            total++;
            if (res !== exp) begin bad++; $display("FAIL roundtrip%0d[%0d]: got %h want %h", 32*nk, i, res, exp); end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

`ifdef AES_DEC_AES256_EN
    task automatic test_aes256();
        int lat; logic rl; logic [127:0] res, exp;
        set_key(KEY256, 8);
        exp_q.push_back(PT);
        do_run(CT256, 1'b1, 0, lat, rl, res);
        exp = exp_q.pop_front();
        total++; if (lat != 71) begin bad++; $display("FAIL aes256_latency: got %0d want 71", lat); end
        total++; if (res !== exp) begin bad++; $display("FAIL aes256_result: got %h want %h", res, exp); end
        set_key(KEY256, 8);
        test_sequence(CT256, 1'b1, 14);
        set_key(KEY256, 8);
        exp_q.push_back(PT);
        do_run(CT256, 1'b1, 2, lat, rl, res);
        exp = exp_q.pop_front();
        total++; if (lat != 71) begin bad++; $display("FAIL aes256_chatter_latency: got %0d want 71", lat); end
        total++; if (res !== exp) begin bad++; $display("FAIL aes256_chatter_result: got %h want %h", res, exp); end
        test_fips128(0, "keylen0");
        test_round_trip(5, 8);
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        reset  = 1'b1;
        next   = 1'b0;
        keyLen = 1'b0;
        block  = 128'h0;
        for (int r = 0; r < 16; r++) rk[r] = 128'h0;
        build_sbox();
        test_reset();
        test_fips128(0, "fips128");
        set_key({KEY128, 128'h0}, 4);
        test_sequence(CT128, 1'b0, 10);
        test_fips128(1, "next_held");
        test_fips128(2, "next_chatter");
        test_back_to_back();
        test_reset_midrun();
        test_round_trip(50, 4);
`ifdef AES_DEC_AES256_EN
        test_aes256();
`endif
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
